avl_accum_slave: RTL and testbench
==================================

AVL_ACCUM_SLAVE -- requirements
Module: avl_accum_slave

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the button-stable time in clk cycles (10 ms at 50 MHz).
REQ-002 SHALL have ports in this order: clk, input, 1, the single 50 MHz clock.
REQ-003 reset_n, input, 1, asynchronous active-low reset.
REQ-004 avs_address, input, 2, register word address.
REQ-005 avs_read, input, 1, read strobe.
REQ-006 avs_write, input, 1, write strobe.
REQ-007 avs_writedata, input, 32, write data.
REQ-008 avs_readdata, output, 32, read data.
REQ-009 avs_waitrequest, output, 1, stall.
REQ-010 sw, input, 8, raw asynchronous switches.
REQ-011 key_n, input, 1, raw asynchronous accumulate button, active-low.
REQ-012 led, output, 8, SUM[7:0].
REQ-013 irq, output, 1, level interrupt.

Function
REQ-014 SHALL pass sw and key_n through 2-flop synchronizers before any use.
REQ-015 SHALL debounce key: a counter reloads on any change of the synchronized key, and the debounced level updates only after DEBOUNCE_CYCLES consecutive stable cycles.
REQ-016 SHALL generate exactly one accumulate event, 1 cycle wide, per debounced press (1->0 transition); release generates no event.
REQ-017 SHALL treat the register map as:
- 0 SUM: R/W, 16 bits, upper bits read as 0.
- 1 SWVAL: RO, the synchronized sw zero-extended.
- 2 CTRL: bit0 IE R/W; bit1 PEND, set on event, write 1 to clear; bit2 OVF, sticky, write 1 to clear.
- 3 COUNT: RO, 16 bits; any write clears it.
REQ-018 On an accumulate event, SHALL set SUM <= SUM + sw_sync modulo 2^16, increment COUNT modulo 2^16, and set PEND.
REQ-019 SHALL set OVF when the 17-bit sum of an accumulate event exceeds 0xFFFF.
REQ-020 irq SHALL equal IE AND PEND, registered, with 1-cycle latency from the state change.
REQ-021 Writes SHALL complete in the strobe cycle with avs_waitrequest=0; the register updates on the next clk edge.
REQ-022 Reads SHALL use one wait state, implemented as a 2-state FSM IDLE->RWAIT->IDLE:
- On the first read cycle, waitrequest=1 and the addressed register is captured.
- On the second cycle, waitrequest=0 and avs_readdata holds the captured value.
- avs_readdata SHALL hold its value until the next read completes.
REQ-023 avs_read and avs_write asserted together SHALL be treated as a write only.
REQ-024 If a bus write to SUM or COUNT and an accumulate event occur in the same cycle:
- The written value SHALL win.
- The event's SUM/COUNT/OVF effects SHALL be dropped.
- PEND SHALL still be set.
REQ-025 If a PEND write-1-clear and an event occur in the same cycle, PEND SHALL end at 1.
REQ-026 led SHALL track SUM[7:0] combinationally from the SUM register.

Reset
REQ-027 Asserting reset_n low SHALL immediately clear SUM, COUNT, IE, PEND, OVF, avs_readdata, irq, led, all synchronizers, and the debounce counter, and SHALL force the FSM to IDLE.
REQ-028 After reset, the debounced key level SHALL be 1 (released).
REQ-029 avs_waitrequest SHALL be 0 during and after reset.
REQ-030 A read in progress when reset asserts SHALL be abandoned, with no completion.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset release, then read addr 0..3: each read SHALL take 2 cycles and return 0; led=0 and irq=0.
REQ-032 sw=0x05; hold key_n low for 10 cycles, then release; repeat 3 times: SUM=0x000F, COUNT=3, led=0x0F, PEND=1.
REQ-033 Bounce key_n 0/1/0 every 2 cycles, then hold low: exactly 1 event SHALL occur.
REQ-034 Write SUM=0xFFF0, sw=0x20, press: SUM=0x0010 and OVF=1; write CTRL=0x4: OVF=0.
REQ-035 Write CTRL=0x1, then press: irq=1 one cycle after PEND sets; write CTRL=0x3: irq=0 on the cycle after.
REQ-036 Force a write SUM=0x1234 in the event cycle: SUM=0x1234, COUNT unchanged, PEND=1.

Source files
------------

// File: rtl/avl_accum_slave.sv
// avl_accum_slave
//   Avalon-MM slave that accumulates the switch value into a 16-bit SUM
//   register on every debounced press of an active-low push button.
//
// Ports
//   clk             50 MHz system clock
//   reset_n         asynchronous active-low reset
//   avs_address     register word address (0 SUM, 1 SWVAL, 2 CTRL, 3 COUNT)
//   avs_read        read strobe (one wait state)
//   avs_write       write strobe (zero wait states, wins over a read)
//   avs_writedata   write data
//   avs_readdata    read data, held until the next read completes
//   avs_waitrequest stall, high only in the first cycle of a read
//   sw              raw asynchronous switches
//   key_n           raw asynchronous accumulate button, active-low
//   led             SUM[7:0]
//   irq             level interrupt, registered IE & PEND
//
// Bus handshake: a write completes in the cycle avs_write is high. A read
// is accepted in IDLE with waitrequest=1 while the register is captured; the
// next cycle (RWAIT) drives waitrequest=0 and avs_readdata carries the data.
module avl_accum_slave #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic [7:0]  sw,
  input  logic        key_n,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_RWAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        sw_meta_q, sw_sync_q;
  logic              key_meta_q, key_sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              key_db_q, key_db_d, key_db_prev_q;
  logic [15:0]       sum_q, sum_d;
  logic [15:0]       count_q, count_d;
  logic              ie_q, ie_d, pend_q, pend_d, ovf_q, ovf_d;
  logic              irq_q;
  logic [31:0]       rdata_q, rd_mux;
  logic              capture, waitreq;
  logic              evt, evt_apply;
  logic              wr_sum, wr_ctrl, wr_cnt, rd_req;
  logic [16:0]       acc17;
  logic              unused_wdata;

  assign unused_wdata = ^avs_writedata[31:16];

  // Synchronizers. The key chain resets to the released level (1) so that
  // leaving reset never looks like a press to the debouncer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= key_n;
      key_sync_q <= key_meta_q;
    end
  end

  // Debounce: the counter runs only while the synchronized key differs from
  // the debounced level; any return to that level (a bounce) reloads it.
  always_comb begin
    cnt_d    = cnt_q;
    key_db_d = key_db_q;
    if (key_sync_q == key_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      key_db_d = key_sync_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // One-cycle event on the debounced 1->0 edge only.
  assign evt = key_db_prev_q & ~key_db_q;

  // Write wins over a simultaneous read.
  assign rd_req  = avs_read & ~avs_write;
  assign wr_sum  = avs_write && (avs_address == 2'd0);
  assign wr_ctrl = avs_write && (avs_address == 2'd2);
  assign wr_cnt  = avs_write && (avs_address == 2'd3);

  // A bus write to SUM or COUNT drops the event's arithmetic; PEND still sets.
  assign evt_apply = evt & ~wr_sum & ~wr_cnt;
  assign acc17     = {1'b0, sum_q} + {9'b0, sw_sync_q};

  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (wr_sum)         sum_d = avs_writedata[15:0];
    else if (evt_apply) sum_d = acc17[15:0];
    if (wr_cnt)         count_d = '0;
    else if (evt_apply) count_d = count_q + 16'd1;
    if (wr_ctrl)        ie_d = avs_writedata[0];
    // Event set beats write-1-clear.
    if (evt)                             pend_d = 1'b1;
    else if (wr_ctrl && avs_writedata[1]) pend_d = 1'b0;
    if (evt_apply && acc17[16])          ovf_d = 1'b1;
    else if (wr_ctrl && avs_writedata[2]) ovf_d = 1'b0;
  end

  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      2'd0: rd_mux = {16'b0, sum_q};
      2'd1: rd_mux = {24'b0, sw_sync_q};
      2'd2: rd_mux = {29'b0, ovf_q, pend_q, ie_q};
      2'd3: rd_mux = {16'b0, count_q};
      default: rd_mux = '0;
    endcase
  end

  // Read FSM: next state and outputs.
  always_comb begin
    state_d = state_q;
    waitreq = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          waitreq = 1'b1;
          capture = 1'b1;
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Held low while reset is asserted even if a master keeps avs_read high.
  assign avs_waitrequest = waitreq & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      sum_q         <= '0;
      count_q       <= '0;
      ie_q          <= 1'b0;
      pend_q        <= 1'b0;
      ovf_q         <= 1'b0;
      irq_q         <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      sum_q         <= sum_d;
      count_q       <= count_d;
      ie_q          <= ie_d;
      pend_q        <= pend_d;
      ovf_q         <= ovf_d;
      irq_q         <= ie_q & pend_q;
      if (capture) rdata_q <= rd_mux;
    end
  end

  assign avs_readdata = rdata_q;
  assign led          = sum_q[7:0];
  assign irq          = irq_q;

endmodule

// File: tb/tb_avl_accum_slave.sv
module tb_avl_accum_slave;

  localparam int DEB = 4;

  logic        clk;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  sw;
  logic        key_n;
  logic [7:0]  led;
  logic        irq;

  avl_accum_slave #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .sw              (sw),
    .key_n           (key_n),
    .led             (led),
    .irq             (irq)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_sum, m_count;
  bit m_ie, m_pend, m_ovf;

  function automatic void model_reset();
    m_sum = 0; m_count = 0; m_ie = 0; m_pend = 0; m_ovf = 0;
  endfunction

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_sum);
      2'd1:    return {24'b0, sw};
      2'd2:    return {29'b0, m_ovf, m_pend, m_ie};
      default: return 32'(m_count);
    endcase
  endfunction

  function automatic void model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: m_sum = int'(d[15:0]);
      2'd2: begin
        m_ie = d[0];
        if (d[1]) m_pend = 0;
        if (d[2]) m_ovf = 0;
      end
      2'd3: m_count = 0;
      default: ;
    endcase
  endfunction

  function automatic void model_event();
    if (m_sum + int'(sw) > 65535) m_ovf = 1;
    m_sum   = (m_sum + int'(sw)) % 65536;
    m_count = (m_count + 1) % 65536;
    m_pend  = 1;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    int wait_cnt;
    logic [31:0] exp;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        wait_cnt = 0;
      end else if (avs_read && !avs_write) begin
        if (avs_waitrequest) begin
          wait_cnt++;
        end else if (wait_cnt > 0) begin
          check("rd_wait_states", 32'(wait_cnt), 32'd1);
          if (exp_q.size() == 0) begin
            check("rd_unexpected", avs_readdata, 32'hxxxx_xxxx);
          end else begin
            exp = exp_q.pop_front();
            check("rd_data", avs_readdata, exp);
          end
          wait_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    check("wr_no_wait", 32'(avs_waitrequest), 32'd0);
    @(posedge clk); #1;
    avs_write = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [1:0] a);
    bit done;
    exp_q.push_back(model_reg(a));
    @(posedge clk); #1;
    avs_address = a; avs_read = 1'b1;
    done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        done = 1;
        break;
      end
    end
    if (!done) check("rd_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  // Press long enough for the event to fire, release, let release debounce.
  task automatic press(input int hold);
    @(posedge clk); #1;
    key_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (10) @(posedge clk);
    model_event();
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("led", 32'(led), 32'(m_sum & 255));
    check("irq", 32'(irq), 32'(m_ie & m_pend));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; avs_address = '0; avs_read = 1'b1; avs_write = 1'b0;
    avs_writedata = '0; sw = '0; key_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_waitreq", 32'(avs_waitrequest), 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    avs_read = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Registers after reset.
    for (int a = 0; a < 4; a++) bus_read(2'(a));
    settle();

    // Three presses of 5.
    sw = 8'h05;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 3; i++) press(10);
    bus_read(2'd0); bus_read(2'd3); bus_read(2'd2);
    settle();

    // Bouncing key: short runs never reach the stable time; final hold does.
    for (int i = 0; i < 6; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    press(10);
    bus_read(2'd3); bus_read(2'd0);
    settle();

    // Overflow and its clear.
    bus_write(2'd0, 32'h0000_FFF0);
    sw = 8'h20;
    repeat (4) @(posedge clk);
    press(10);
    bus_read(2'd0); bus_read(2'd2);
    bus_write(2'd2, 32'h4);
    bus_read(2'd2);
    settle();

    // Interrupt timing: PEND sets at the 7th edge after key_n falls.
    bus_write(2'd2, 32'h2);
    bus_write(2'd2, 32'h1);
    settle();
    @(posedge clk); #1 key_n = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'd1);
    model_event();
    #1 key_n = 1'b1;
    repeat (10) @(posedge clk);
    bus_write(2'd2, 32'h3);
    @(negedge clk);
    check("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_fall", 32'(irq), 32'd0);
    bus_read(2'd2);

    // Write to SUM in the event cycle.
    bus_write(2'd2, 32'h2);
    sw = 8'h11;
    repeat (4) @(posedge clk);
    @(posedge clk); #1 key_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 avs_address = 2'd0; avs_writedata = 32'h1234; avs_write = 1'b1;
    @(posedge clk); #1 avs_write = 1'b0;
    m_sum  = 32'h1234;
    m_pend = 1;
    repeat (3) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (10) @(posedge clk);
    bus_read(2'd0); bus_read(2'd3); bus_read(2'd2);
    settle();

    // Read and write together act as a write only.
    @(posedge clk); #1;
    avs_address = 2'd0; avs_writedata = 32'hABCD; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    check("rw_no_wait", 32'(avs_waitrequest), 32'd0);
    @(posedge clk); #1 avs_read = 1'b0; avs_write = 1'b0;
    model_write(2'd0, 32'hABCD);
    bus_read(2'd0);

    // Randomized mix.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0: bus_write(2'd0, $urandom);
        1: bus_write(2'd2, 32'($urandom_range(0, 7)));
        2: bus_write(2'd3, $urandom);
        3: bus_write(2'd1, $urandom);
        4: begin
          sw = 8'($urandom_range(0, 255));
          repeat (4) @(posedge clk);
          press($urandom_range(8, 12));
        end
        default: bus_read(2'($urandom_range(0, 3)));
      endcase
      settle();
    end
    for (int a = 0; a < 4; a++) bus_read(2'(a));

    // Reset in the middle of a read abandons it.
    @(posedge clk); #1 avs_address = 2'd0; avs_read = 1'b1;
    @(negedge clk);
    check("rd_pre_reset_wait", 32'(avs_waitrequest), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_waitreq", 32'(avs_waitrequest), 32'd0);
    check("async_rst_rdata", avs_readdata, 32'd0);
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    model_reset();
    @(posedge clk); #1 avs_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    for (int a = 0; a < 4; a++) if (a != 1) bus_read(2'(a));
    settle();

    repeat (5) @(posedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
